// File: rtl/shift_chain_loader_if.sv
// shift_chain_loader_if: valid/ready handshake carrying a parallel configuration word
interface shift_chain_loader_if #(
  parameter int CHAIN_LEN = 124
);
  logic load_valid;
  logic load_ready;
  logic [CHAIN_LEN-1:0] load_data;
  modport master(output load_valid, output load_data, input load_ready);
  modport slave(input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/shift_chain_loader.sv
// shift_chain_loader: MSB-first serial loader for the config chain; SHIFT_READBACK_EN builds the readback capture
module shift_chain_loader #(
  parameter int CHAIN_LEN = 124,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_chain_loader_if.slave  ld,
  input  logic                 hold,
  output logic                 sh_data,
  output logic                 sh_en,
  input  logic                 chain_out,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] readback
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic accept, step, last;
  assign accept = state == IDLE && ld.load_valid;
  assign step = state == SHIFT && !hold;
  assign last = cnt == CNT_W'(CHAIN_LEN - 1);
  assign ld.load_ready = state == IDLE && !reset;
  assign sh_data = shadow[CHAIN_LEN-1];
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    sh_en = step && !reset;
    done = state == DONE;
    busy = state != IDLE;
    state_nx = accept ? SHIFT : step && last ? DONE : state == DONE ? IDLE : state;
  end
  // shadow is fully shifted out by the end of a load, so sh_data idles at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      cnt <= '0;
    end else if (accept) begin
      shadow <= ld.load_data;
      cnt <= '0;
    end else if (step) begin
      shadow <= shadow << 1;
      cnt <= cnt + 1'b1;
    end
  end
`ifdef SHIFT_READBACK_EN
  logic [CHAIN_LEN-1:0] rb;
  always_ff @(posedge clk) begin
    if (reset) rb <= '0;
    else if (step) rb <= {rb[CHAIN_LEN-2:0], chain_out};
  end
  assign readback = rb;
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign readback = '0;
`endif
endmodule

// File: tb/tb_shift_chain_loader.sv
// tb_shift_chain_loader: directed scoreboard bench driving a behavioural chain model
module tb_shift_chain_loader;
  localparam int W = 124;
  localparam logic [W-1:0] PAT_A = 124'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0;
`ifdef SHIFT_READBACK_EN
  localparam bit RB_ON = 1'b1;
`else
  localparam bit RB_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, hold, sh_data, sh_en, chain_out, busy, done;
  logic [W-1:0] readback;
  logic [W-1:0] chain = '0;
  logic [W-1:0] pa, pb;
  logic [W-1:0] exp_q[$], rb_q[$];
  int cyc = 0;
  int last_acc = 0;
  int n_cmp = 0, n_err = 0;
  shift_chain_loader_if #(.CHAIN_LEN(W)) ld();
  shift_chain_loader #(.CHAIN_LEN(W), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .ld(ld), .hold(hold), .sh_data(sh_data), .sh_en(sh_en),
    .chain_out(chain_out), .busy(busy), .done(done), .readback(readback)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sh_en) chain <= {chain[W-2:0], sh_data};
  assign chain_out = chain[W-1];
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input string tag, input logic [W-1:0] w, input int hold_at, input int hold_len,
                         input logic keep_valid, input logic [W-1:0] nxt, input bit chk_period);
    int t, ens, hc, done_c;
    ld.load_valid = 1'b1;
    ld.load_data = w;
    #1;
    t = 0;
    while (ld.load_ready !== 1'b1 && t < 300) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({tag, ".ready"}, ld.load_ready, 1);
    if (chk_period) chk({tag, ".period"}, cyc - last_acc, W + 2);
    last_acc = cyc;
    exp_q.push_back(w);
    rb_q.push_back(RB_ON ? chain : '0);
    @(posedge clk);
    #1;
    ld.load_valid = keep_valid;
    ld.load_data = nxt;
    ens = 0;
    hc = 0;
    done_c = 0;
    for (int c = 1; c <= 200 && done_c == 0; c++) begin
      hold = ens == hold_at && hc < hold_len;
      #1;
      if (hold) begin
        hc++;
        chk({tag, ".hold_en"}, sh_en, 0);
      end
      if (c == 10) chk({tag, ".busy_ready"}, {busy, ld.load_ready}, 2'b10);
      if (sh_en) ens++;
      if (done) done_c = c;
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    #1;
    chk({tag, ".done_at"}, done_c, 125 + hold_len);
    chk({tag, ".shifts"}, ens, W);
    chk({tag, ".done_width"}, done, 0);
    chk({tag, ".ready_back"}, ld.load_ready, 1);
    chk({tag, ".chain"}, chain, exp_q.pop_front());
    chk({tag, ".readback"}, readback, rb_q.pop_front());
  endtask
  initial begin
    int ens, t;
    pa = PAT_A;
    pb = ~PAT_A;
    reset = 1'b1;
    hold = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.sh_en", sh_en, 0);
    chk("rst.sh_data", sh_data, 0);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.readback", readback, 0);
    chk("rst.ready_low", ld.load_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst.ready", ld.load_ready, 1);
    @(posedge clk);
    #1;
    do_load("A", pa, -1, 0, 1'b1, pb, 1'b0);
    do_load("B", pb, -1, 0, 1'b0, '0, 1'b1);
    chk("B.rb_is_A", readback, RB_ON ? pa : '0);
    do_load("H", pa, 60, 5, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    ld.load_valid = 1'b1;
    ld.load_data = pb;
    #1;
    chk("R.ready", ld.load_ready, 1);
    @(posedge clk);
    #1;
    ld.load_valid = 1'b0;
    ld.load_data = '1;
    ens = 0;
    t = 0;
    while (ens < 40 && t < 200) begin
      #1;
      if (sh_en) ens++;
      @(posedge clk);
      #1;
      t++;
    end
    chk("R.count", ens, 40);
    reset = 1'b1;
    #1;
    chk("R.sh_en_now", sh_en, 0);
    chk("R.ready_low", ld.load_ready, 0);
    @(posedge clk);
    #1;
    chk("R.busy", busy, 0);
    chk("R.done", done, 0);
    chk("R.sh_en", sh_en, 0);
    chk("R.readback", readback, 0);
    reset = 1'b0;
    #1;
    chk("R.ready", ld.load_ready, 1);
    chk("R.chain_partial", chain, {pa[W-41:0], pb[W-1:W-40]});
    @(posedge clk);
    #1;
    chk("R.no_done", done, 0);
    do_load("ONES", '1, -1, 0, 1'b0, '0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end
endmodule

// File: doc/shift_chain_loader.md
# shift_chain_loader

Serial load controller for the 124-stage configuration shift chain. Accepts a parallel configuration word over a valid/ready handshake and drives the chain's serial input and shift enable for exactly CHAIN_LEN shifts, MSB first, so that stage i holds bit i when the load completes. It optionally captures the chain's previous contents from its serial output for readback. It sits between the host/config register bank and the shift chain.

## Interface
- CHAIN_LEN, 124, number of chain stages and the width of a configuration word
- CNT_W, 7, shift counter width; must satisfy 2^CNT_W > CHAIN_LEN
- clk  input  1  rising-edge clock, shared with the chain
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  host offers load_data
- load_ready  output  1  controller can accept a word
- load_data  input  CHAIN_LEN  configuration word; bit i is destined for stage i
- hold  input  1  pauses shifting while high
- sh_data  output  1  drives the chain's data_in
- sh_en  output  1  drives the chain's shift_en; the chain advances one stage per clk edge while high
- chain_out  input  1  the chain's data_out (last stage)
- busy  output  1  a load is in progress
- done  output  1  one-cycle pulse when a load completes
- readback  output  CHAIN_LEN  chain contents captured before the last load; bit i is the old stage i

## Operation
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: latch load_data into the shadow register, clear the counter, go to SHIFT.
- SHIFT:
  - When hold=0: sh_en=1; sh_data=shadow[CHAIN_LEN-1]. At the edge, the shadow shifts left by one, the counter increments, and readback shifts left with chain_out inserted at bit 0.
  - When hold=1: sh_en=0; sh_data, shadow, counter and readback are frozen.
  - When the counter reaches CHAIN_LEN (on the edge of the CHAIN_LEN-th enabled shift), go to DONE.
- DONE: done=1, sh_en=0, then go to IDLE.
- busy=1 in SHIFT and DONE. load_ready=0 outside IDLE and while reset=1.
- load_valid outside IDLE is ignored, and load_data is not re-sampled.
- hold has no effect in IDLE or DONE. The done pulse is never stretched.
- Arithmetic: the counter is unsigned CNT_W bits and never wraps, because it stops at CHAIN_LEN.

## Timing
- Reset values: state=IDLE, sh_en=0, sh_data=0, done=0, busy=0, shadow=0, counter=0, readback=0. reset has priority over every other input.
- Handshake accepted at edge E0 → sh_en=1 in cycles E0+1 … E0+CHAIN_LEN, provided hold stays low.
- done=1 in cycle E0+CHAIN_LEN+1; load_ready=1 again in cycle E0+CHAIN_LEN+2.
- Each hold-high cycle in SHIFT adds exactly one cycle to this schedule.
- Minimum word period with load_valid held high: CHAIN_LEN+2 cycles (126 at the default).
- sh_en, sh_data, done and busy are registered, or decoded directly from registered state. No combinational path exists from load_valid or hold to sh_data.
- Reset in mid-SHIFT: IDLE at the next edge and sh_en=0 immediately. Chain contents are left partially shifted and are undefined. readback is cleared. No done pulse is generated.
- readback updates only in SHIFT cycles with hold=0. It is stable from the done cycle until the next accepted load.

## Configuration
- SHIFT_READBACK_EN:
  - Defined: the readback capture register is built and behaves as described above.
  - Undefined: no readback storage exists; readback is tied to all zeros; chain_out is unused. Handshake, FSM and sh_* timing are unchanged.

## Test plan
- Reset then single load, no hold: load_data=124'h0F…(alternating pattern A) accepted at cycle 0 → sh_en high for exactly 124 cycles, done pulses at cycle 125, the chain model holds pattern A with stage i = bit i, load_ready returns at cycle 126.
- Back-to-back loads with load_valid held high: pattern A then pattern B (~A) → B accepted 126 cycles after A. With SHIFT_READBACK_EN, readback==A after load B.
- Hold insertion: hold high for 5 cycles starting at shift 60 → sh_en low for exactly those 5 cycles, done at cycle 130, chain contents correct.
- Reset mid-shift: reset high at shift 40 → next cycle shows IDLE, sh_en=0, busy=0, readback=0, no done. A subsequent load of all ones completes normally.
- Ignored input: load_valid with new data asserted during SHIFT → original word loaded; new word not accepted until load_ready=1.
- Macro off: rerun the back-to-back test without SHIFT_READBACK_EN → readback is always 0 and sh_en/done timing is identical.
